// File: rtl/fpga_sdpram_rd_stream_pkg.sv
// Shared types and sizing helpers for the SDP RAM burst reader.
//   state_e    : burst FSM state encoding (2 bits)
//   fifo_depth : output FIFO depth needed to absorb a given RAM read latency
package fpga_sdpram_rd_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    // Every read in the RAM pipe plus the one being presented needs a slot.
    function automatic int unsigned fifo_depth(input int unsigned read_laten);
        return read_laten + 32'd2;
    endfunction

endpackage

// File: rtl/fpga_rd_skid_fifo.sv
// Register-based first-word-fall-through FIFO with occupancy count.
//   clk, rst_n : clock, async active-low reset
//   push_i     : write din_i (ignored when full and not popping)
//   din_i      : write data
//   pop_i      : consume head word (ignored when empty)
//   dout_o     : head word, stable until popped
//   vld_o      : head word valid
//   cnt_o      : number of stored words
module fpga_rd_skid_fifo #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       vld_o,
    output logic [$clog2(DEPTH+1)-1:0] cnt_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             vld_q;
    logic             pop_ok;
    logic             push_ok;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok  = pop_i && (cnt_q != '0);
    assign push_ok = push_i && ((cnt_q != CNT_W'(DEPTH)) || pop_ok);

    // Occupancy next state; simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Storage, pointers and registered valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            vld_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_d;
            vld_q <= (cnt_d != '0);
        end
    end

    assign dout_o = mem_q[rd_ptr_q];
    assign vld_o  = vld_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/fpga_sdpram_rd_stream.sv
// Burst reader for the read port of a common-clock simple dual-port RAM.
// Converts a (base, length) command into rd/addrb requests, tracks the fixed
// RAM read latency and returns the words on a valid/ready stream.
//   clka, rstb_n       : clock, async active-low reset
//   start, base_addr,
//   length             : command (sampled only when idle; length 0 = empty burst)
//   busy, done         : command in progress / one-cycle completion pulse
//   rd, addrb, doutb   : RAM read port
//   dout, dout_vld,
//   dout_rdy           : output stream with full backpressure
module fpga_sdpram_rd_stream
    import fpga_sdpram_rd_stream_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned READ_LATEN = 1,
    parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clka,
    input  logic                  rstb_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  rd,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_vld,
    input  logic                  dout_rdy
);

    localparam int unsigned FIFO_DEPTH = fifo_depth(READ_LATEN);
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W      = CNT_W + 2;

    state_e                state_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rd_q;
    logic                  busy_q;
    logic                  done_q;
    logic [READ_LATEN-1:0] vpipe_q;

    logic [CNT_W-1:0]      fifo_cnt;
    logic                  fifo_vld;
    logic                  pop_c;
    logic [CNT_W-1:0]      in_flight_c;
    logic [SUM_W-1:0]      commit_c;
    logic                  credit_ok_c;
    logic                  drained_c;

    assign pop_c = fifo_vld && dout_rdy;

    // Reads sitting in the RAM latency pipe.
    always_comb begin
        in_flight_c = '0;
        for (int i = 0; i < int'(READ_LATEN); i++) begin
            in_flight_c = in_flight_c + CNT_W'(vpipe_q[i]);
        end
    end

    // Committed FIFO slots: the read on the RAM port now, the latency pipe and
    // the FIFO contents, less the word leaving this cycle. Counting the pop
    // keeps one-word-per-cycle throughput; counting rd_q keeps it overflow-safe.
    assign commit_c    = SUM_W'(rd_q) + SUM_W'(in_flight_c) + SUM_W'(fifo_cnt) - SUM_W'(pop_c);
    assign credit_ok_c = (commit_c < SUM_W'(FIFO_DEPTH));

    // Nothing left anywhere once the current handshake (if any) completes.
    assign drained_c = !rd_q && (vpipe_q == '0) &&
                       ((fifo_cnt == '0) || ((fifo_cnt == CNT_W'(1)) && pop_c));

    // Burst FSM with registered outputs; the first read is issued straight from IDLE.
    always_ff @(posedge clka or negedge rstb_n) begin
        if (!rstb_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            rd_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (length == '0) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            rd_q    <= 1'b1;
                            addr_q  <= base_addr;
                            rem_q   <= length - 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (rem_q == '0) begin
                        state_q <= ST_DRAIN;
                    end else if (credit_ok_c) begin
                        rd_q   <= 1'b1;
                        addr_q <= addr_q + 1'b1;
                        rem_q  <= rem_q - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drained_c) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // One bit per issued read, aligned with doutb at the pipe output.
    always_ff @(posedge clka or negedge rstb_n) begin
        if (!rstb_n) begin
            vpipe_q <= '0;
        end else begin
            vpipe_q <= READ_LATEN'({vpipe_q, rd_q});
        end
    end

    fpga_rd_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk    (clka),
        .rst_n  (rstb_n),
        .push_i (vpipe_q[READ_LATEN-1]),
        .din_i  (doutb),
        .pop_i  (pop_c),
        .dout_o (dout),
        .vld_o  (fifo_vld),
        .cnt_o  (fifo_cnt)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd       = rd_q;
    assign addrb    = addr_q;
    assign dout_vld = fifo_vld;

endmodule

// File: tb/tb_fpga_sdpram_rd_stream.sv
// Bench for fpga_sdpram_rd_stream: two instances (read latency 1 and 3) share
// command and ready stimulus; each has its own behavioural RAM and is compared
// against a burst-level model of expected addresses, data and timing.
module tb_fpga_sdpram_rd_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [5:0] base = '0;
    logic [6:0] len = '0;
    logic       rdy = 1'b0;

    logic       busy_w  [2];
    logic       done_w  [2];
    logic       rd_w    [2];
    logic [5:0] addrb_w [2];
    logic [5:0] doutb_w [2];
    logic [5:0] dout_w  [2];
    logic       vld_w   [2];

    logic [5:0] mem [64];
    logic [5:0] p1;
    logic [5:0] p3 [3];

    int checks = 0;
    int errors = 0;

    // Burst-level model state per instance.
    logic [5:0] cur_base;
    int         cur_len;
    int         cyc_n;
    int         issued    [2];
    int         recv      [2];
    int         first_rd  [2];
    int         first_vld [2];
    int         done_cyc  [2];
    bit         fin       [2];
    bit         prev_stall[2];
    logic [5:0] prev_dout [2];

    always #5 clk = ~clk;

    fpga_sdpram_rd_stream #(.ADDR_WIDTH(6), .DATA_WIDTH(6), .READ_LATEN(1)) u_dut1 (
        .clka(clk), .rstb_n(rst_n), .start(start), .base_addr(base), .length(len),
        .busy(busy_w[0]), .done(done_w[0]), .rd(rd_w[0]), .addrb(addrb_w[0]),
        .doutb(doutb_w[0]), .dout(dout_w[0]), .dout_vld(vld_w[0]), .dout_rdy(rdy)
    );

    fpga_sdpram_rd_stream #(.ADDR_WIDTH(6), .DATA_WIDTH(6), .READ_LATEN(3)) u_dut3 (
        .clka(clk), .rstb_n(rst_n), .start(start), .base_addr(base), .length(len),
        .busy(busy_w[1]), .done(done_w[1]), .rd(rd_w[1]), .addrb(addrb_w[1]),
        .doutb(doutb_w[1]), .dout(dout_w[1]), .dout_vld(vld_w[1]), .dout_rdy(rdy)
    );

    // Behavioural RAMs: data appears READ_LATEN cycles after rd; junk otherwise.
    always @(posedge clk) p1 <= rd_w[0] ? mem[addrb_w[0]] : 6'($urandom);
    always @(posedge clk) begin
        p3[0] <= rd_w[1] ? mem[addrb_w[1]] : 6'($urandom);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign doutb_w[0] = p1;
    assign doutb_w[1] = p3[2];

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_rd"},    32'(rd_w[d]),    0);
            chk({tag, "_addrb"}, 32'(addrb_w[d]), 0);
            chk({tag, "_busy"},  32'(busy_w[d]),  0);
            chk({tag, "_done"},  32'(done_w[d]),  0);
            chk({tag, "_dout"},  32'(dout_w[d]),  0);
            chk({tag, "_vld"},   32'(vld_w[d]),   0);
        end
    endtask

    task automatic begin_model(input logic [5:0] b, input int l);
        cur_base = b;
        cur_len  = l;
        cyc_n    = -1;
        for (int d = 0; d < 2; d++) begin
            issued[d] = 0; recv[d] = 0; first_rd[d] = -1; first_vld[d] = -1;
            done_cyc[d] = -1; fin[d] = 1'b0; prev_stall[d] = 1'b0;
        end
    endtask

    // One clock: drive this cycle's inputs at the falling edge, then check outputs.
    task automatic cyc(input logic rdy_v, input logic start_v, input logic [5:0] b_v,
                       input logic [6:0] l_v);
        @(negedge clk);
        rdy = rdy_v; start = start_v; base = b_v; len = l_v;
        cyc_n++;
        for (int d = 0; d < 2; d++) begin
            if (prev_stall[d]) begin
                chk("stall_vld",  32'(vld_w[d]),  1);
                chk("stall_data", 32'(dout_w[d]), 32'(prev_dout[d]));
            end
            chk("busy", 32'(busy_w[d]), 32'((cyc_n >= 1) && !fin[d]));
            if (rd_w[d]) begin
                if (first_rd[d] < 0) first_rd[d] = cyc_n;
                chk("rd_addr", 32'(addrb_w[d]), 32'(6'(cur_base + 6'(issued[d]))));
                issued[d]++;
                chk("rd_count", 32'(issued[d] <= cur_len), 1);
            end
            if (vld_w[d] && first_vld[d] < 0) first_vld[d] = cyc_n;
            if (vld_w[d] && rdy) begin
                chk("data", 32'(dout_w[d]), 32'(mem[6'(cur_base + 6'(recv[d]))]));
                recv[d]++;
                chk("recv_count", 32'(recv[d] <= cur_len), 1);
            end
            if (done_w[d]) begin
                chk("done_once",   32'(fin[d]), 0);
                chk("done_recv",   recv[d],   cur_len);
                chk("done_issued", issued[d], cur_len);
                fin[d] = 1'b1;
                done_cyc[d] = cyc_n;
            end
            prev_stall[d] = vld_w[d] && !rdy;
            prev_dout[d]  = dout_w[d];
        end
    endtask

    // mode 0: ready held high, 1: random ready, 2: ready low through cycle 10.
    task automatic run_burst(input logic [5:0] b, input int l, input int mode, input bit stray);
        logic r;
        begin_model(b, l);
        r = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 0);
        cyc(r, 1'b1, b, 7'(l));
        for (int c = 1; c < 400 && !(fin[0] && fin[1]); c++) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (c > 10);
            cyc(r, stray && c >= 3 && c <= 5, 6'($urandom), 7'($urandom));
            if (mode == 2 && cyc_n == 10) begin
                for (int d = 0; d < 2; d++) chk("credit_stop", issued[d], lat(d) + 2);
            end
        end
        chk("burst_end", 32'(fin[0] && fin[1]), 1);
        if (mode == 0) begin
            for (int d = 0; d < 2; d++) begin
                if (l > 0) begin
                    chk("first_rd",  first_rd[d],  1);
                    chk("first_vld", first_vld[d], 2 + lat(d));
                    chk("done_cyc",  done_cyc[d],  2 + lat(d) + l);
                end else begin
                    chk("empty_rd",   first_rd[d], -1);
                    chk("empty_done", done_cyc[d], 1);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 6'(i);
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Contiguous burst, then address wrap.
        run_burst(6'd4, 8, 0, 1'b0);
        run_burst(6'd60, 6, 0, 1'b0);

        // Random contents with backpressure.
        for (int i = 0; i < 64; i++) mem[i] = 6'($urandom);
        for (int k = 0; k < 3; k++) run_burst(6'($urandom), 8, 1, 1'b0);
        run_burst(6'd10, 8, 2, 1'b0);

        // Empty burst.
        run_burst(6'd7, 0, 0, 1'b0);

        // Starts while busy are ignored; immediate follow-on is accepted.
        run_burst(6'd30, 8, 0, 1'b1);
        run_burst(6'd33, 5, 1, 1'b0);

        // Reset mid-burst with reads still in the latency pipe.
        begin_model(6'd20, 8);
        cyc(1'b1, 1'b1, 6'd20, 7'd8);
        repeat (4) cyc(1'b1, 1'b0, 6'd0, 7'd0);
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) chk("rst_no_done", 32'(done_w[d]), 0);
        end
        rst_n = 1'b1;
        run_burst(6'd50, 8, 1, 1'b0);

        // Assorted random bursts, including a full-address-space one.
        for (int k = 0; k < 4; k++) run_burst(6'($urandom), $urandom_range(1, 20), 1, 1'b0);
        run_burst(6'($urandom), 64, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
